// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } bcd_state_t;

    // Default operand width and number of decimal digits produced.
    localparam int DEF_BIN_W  = 16;
    localparam int DEF_DIGITS = 5;

    // Width of the significant-digit count (holds 1..DEF_DIGITS).
    localparam int CNT_W = 3;

endpackage

// File: rtl/bcd_convert_seq_if.sv
// Start/done handshake and result bus between the multiplier result path
// (master) and the BCD converter (slave).
interface bcd_convert_seq_if #(
    parameter int BIN_W  = bcd_pkg::DEF_BIN_W,
    parameter int DIGITS = bcd_pkg::DEF_DIGITS
);
    logic                      start;
    logic [BIN_W-1:0]          bin_in;
    logic                      is_signed;
    logic                      busy;
    logic                      done;
    logic [4*DIGITS-1:0]       bcd_out;
    logic                      sign_out;
    logic [bcd_pkg::CNT_W-1:0] digit_count;

    modport master (
        output start, bin_in, is_signed,
        input  busy, done, bcd_out, sign_out, digit_count
    );

    modport slave (
        input  start, bin_in, is_signed,
        output busy, done, bcd_out, sign_out, digit_count
    );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD digit above 4 gets 3 added so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din > 4'd4) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter. Takes the magnitude of a signed or
// unsigned operand and runs double-dabble one bit per clock through a single
// shared bank of add-3 cells. Results are held stable between done pulses.
module bcd_convert_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_convert_seq_if.slave   bus
);

    localparam int SCR_W = 4 * DIGITS;
    localparam int CTR_W = $clog2(BIN_W + 1);

    bcd_state_t        state_q,   state_d;
    logic [BIN_W-1:0]  bin_q,     bin_d;
    logic              signed_q,  signed_d;
    logic [BIN_W-1:0]  mag_q,     mag_d;
    logic              neg_q,     neg_d;
    logic [SCR_W-1:0]  scratch_q, scratch_d;
    logic [CTR_W-1:0]  ctr_q,     ctr_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic [SCR_W-1:0]  bcd_q,     bcd_d;
    logic              sign_q,    sign_d;
    logic [CNT_W-1:0]  count_q,   count_d;

    logic [SCR_W-1:0]  scratch_adj;
    logic [SCR_W-1:0]  scratch_sh;
    logic [CNT_W-1:0]  count_next;

    // One add-3 correction cell per digit, all applied in parallel before the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch_q[4*g +: 4]),
            .dout (scratch_adj[4*g +: 4])
        );
    end

    // {scratch, magnitude} is treated as one rotating register: the digit bank
    // takes the next magnitude bit, and its own top bit wraps into the vacated
    // magnitude LSB. That top bit is always zero for in-range operands, and the
    // wrapped bits are never read, so this behaves as a plain left shift.
    assign scratch_sh = {scratch_adj[SCR_W-2:0], mag_q[BIN_W-1]};

    // Significant digits of the final scratch value: highest nonzero digit + 1, minimum 1.
    always_comb begin
        count_next = CNT_W'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_sh[4*i +: 4] != 4'd0) begin
                count_next = CNT_W'(i + 1);
            end
        end
    end

    // Controller next-state logic; outputs are loaded only on entry to DONE.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        signed_d  = signed_q;
        mag_d     = mag_q;
        neg_d     = neg_q;
        scratch_d = scratch_q;
        ctr_d     = ctr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        sign_d    = sign_q;
        count_d   = count_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bin_d    = bus.bin_in;
                    signed_d = bus.is_signed;
                    busy_d   = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (signed_q && bin_q[BIN_W-1]) begin
                    mag_d = -bin_q;
                    neg_d = 1'b1;
                end else begin
                    mag_d = bin_q;
                    neg_d = 1'b0;
                end
                scratch_d = '0;
                ctr_d     = CTR_W'(BIN_W);
                state_d   = SHIFT;
            end
            SHIFT: begin
                scratch_d = scratch_sh;
                mag_d     = {mag_q[BIN_W-2:0], scratch_adj[SCR_W-1]};
                ctr_d     = ctr_q - CTR_W'(1);
                if (ctr_q == CTR_W'(1)) begin
                    done_d  = 1'b1;
                    bcd_d   = scratch_sh;
                    sign_d  = neg_q;
                    count_d = count_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    bin_d    = bus.bin_in;
                    signed_d = bus.is_signed;
                    state_d  = LOAD;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            signed_q  <= 1'b0;
            mag_q     <= '0;
            neg_q     <= 1'b0;
            scratch_q <= '0;
            ctr_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            sign_q    <= 1'b0;
            count_q   <= CNT_W'(1);
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            signed_q  <= signed_d;
            mag_q     <= mag_d;
            neg_q     <= neg_d;
            scratch_q <= scratch_d;
            ctr_q     <= ctr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            sign_q    <= sign_d;
            count_q   <= count_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.bcd_out     = bcd_q;
    assign bus.sign_out    = sign_q;
    assign bus.digit_count = count_q;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Testbench for bcd_convert_seq: directed cases plus randomized conversions
// checked against a decimal-arithmetic reference model.
module tb_bcd_convert_seq;

    localparam int BIN_W   = 16;
    localparam int DIGITS  = 5;
    localparam int LATENCY = BIN_W + 2;
    localparam int TIMEOUT = 40;

    logic clk;
    logic rst_n;

    int assertCount = 0;
    int failCount   = 0;

    // Expected {bcd_out, sign_out, digit_count} currently held by the DUT.
    logic [4*DIGITS+3:0] prevOut;

    bcd_convert_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bcd_convert_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: signed/unsigned interpretation, decimal digits by division.
    function automatic void refModel(input logic [BIN_W-1:0] v, input logic s,
                                     output logic [4*DIGITS-1:0] bcd,
                                     output logic sg, output logic [2:0] cnt);
        int val;
        int m;
        int d;
        val = s ? int'($signed(v)) : int'({16'd0, v});
        sg  = (val < 0);
        m   = sg ? -val : val;
        bcd = '0;
        cnt = 3'd1;
        for (int i = 0; i < DIGITS; i++) begin
            d = m % 10;
            m = m / 10;
            bcd[4*i +: 4] = d[3:0];
            if (d != 0) cnt = 3'(i + 1);
        end
    endfunction

    // Single comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for done, sampling at negedges; optionally hold start or pulse it mid-conversion.
    task automatic waitDone(input bit holdStart, input int pulseAt,
                            input logic [BIN_W-1:0] nextBin, input logic nextSigned,
                            output int cycles, output bit busyOk, output bit stableOk);
        cycles   = 0;
        busyOk   = 1'b1;
        stableOk = 1'b1;
        do begin
            @(negedge clk);
            cycles++;
            bus.start = holdStart || (cycles == pulseAt);
            if (cycles == 1) begin
                bus.bin_in    = nextBin;
                bus.is_signed = nextSigned;
            end
            if (!bus.busy) busyOk = 1'b0;
            if (!bus.done && ({bus.bcd_out, bus.sign_out, bus.digit_count} !== prevOut))
                stableOk = 1'b0;
        end while (!bus.done && cycles < TIMEOUT);
    endtask

    // Compare one finished conversion against the model and its timing.
    task automatic checkResult(input string tag, input logic [BIN_W-1:0] v, input logic s,
                               input int cycles, input bit busyOk, input bit stableOk);
        logic [4*DIGITS-1:0] eBcd;
        logic eSign;
        logic [2:0] eCnt;
        refModel(v, s, eBcd, eSign, eCnt);
        checkOutput($sformatf("%s latency", tag), 32'(cycles), 32'(LATENCY));
        checkOutput($sformatf("%s busy", tag), 32'(busyOk), 32'd1);
        checkOutput($sformatf("%s held", tag), 32'(stableOk), 32'd1);
        checkOutput($sformatf("%s bcd", tag), 32'(bus.bcd_out), 32'(eBcd));
        checkOutput($sformatf("%s sign", tag), 32'(bus.sign_out), 32'(eSign));
        checkOutput($sformatf("%s count", tag), 32'(bus.digit_count), 32'(eCnt));
        prevOut = {eBcd, eSign, eCnt};
    endtask

    // Issue one start pulse from IDLE and wait for its result.
    task automatic applyStimulus(input string tag, input logic [BIN_W-1:0] v, input logic s,
                                 input int pulseAt);
        int cycles;
        bit busyOk;
        bit stableOk;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.bin_in    = v;
        bus.is_signed = s;
        waitDone(1'b0, pulseAt, BIN_W'($urandom), 1'($urandom), cycles, busyOk, stableOk);
        checkResult(tag, v, s, cycles, busyOk, stableOk);
    endtask

    // Confirm the controller returned to idle after a done cycle.
    task automatic checkIdle(input string tag);
        @(negedge clk);
        checkOutput($sformatf("%s idle busy", tag), 32'(bus.busy), 32'd0);
        checkOutput($sformatf("%s idle done", tag), 32'(bus.done), 32'd0);
    endtask

    // Directed sequence followed by randomized conversions.
    initial begin
        int cycles;
        bit busyOk;
        bit stableOk;
        bit sawDone;
        logic [BIN_W-1:0] v;
        logic s;
        logic [BIN_W-1:0] edgeVals [4];

        edgeVals[0] = 16'h0000;
        edgeVals[1] = 16'h8000;
        edgeVals[2] = 16'hFFFF;
        edgeVals[3] = 16'h7FFF;

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.bin_in    = '0;
        bus.is_signed = 1'b0;
        prevOut       = {20'h00000, 1'b0, 3'd1};

        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset bcd", 32'(bus.bcd_out), 32'h0);
        checkOutput("reset sign", 32'(bus.sign_out), 32'd0);
        checkOutput("reset count", 32'(bus.digit_count), 32'd1);
        rst_n = 1'b1;

        $display("[TB] unsigned maximum");
        applyStimulus("u_ffff", 16'hFFFF, 1'b0, 0);
        checkIdle("u_ffff");

        $display("[TB] reset during conversion");
        @(negedge clk);
        bus.start     = 1'b1;
        bus.bin_in    = 16'd1234;
        bus.is_signed = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        checkOutput("abort done", 32'(bus.done), 32'd0);
        checkOutput("abort bcd", 32'(bus.bcd_out), 32'h0);
        checkOutput("abort count", 32'(bus.digit_count), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sawDone = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done || bus.busy) sawDone = 1'b1;
        end
        checkOutput("abort no done", 32'(sawDone), 32'd0);
        prevOut = {20'h00000, 1'b0, 3'd1};

        $display("[TB] signed cases");
        applyStimulus("s_m1234", 16'hFB2E, 1'b1, 0);
        checkOutput("s_m1234 bcd literal", 32'(bus.bcd_out), 32'h01234);
        checkIdle("s_m1234");
        applyStimulus("s_min", 16'h8000, 1'b1, 6);
        checkOutput("s_min bcd literal", 32'(bus.bcd_out), 32'h32768);
        applyStimulus("s_zero", 16'h0000, 1'b1, 0);
        checkOutput("s_zero sign literal", 32'(bus.sign_out), 32'd0);
        checkIdle("s_zero");

        $display("[TB] back-to-back");
        @(negedge clk);
        bus.start     = 1'b1;
        bus.bin_in    = 16'd7;
        bus.is_signed = 1'b0;
        waitDone(1'b1, 0, 16'd99, 1'b0, cycles, busyOk, stableOk);
        checkResult("b2b_7", 16'd7, 1'b0, cycles, busyOk, stableOk);
        waitDone(1'b0, 5, 16'd4321, 1'b1, cycles, busyOk, stableOk);
        checkResult("b2b_99", 16'd99, 1'b0, cycles, busyOk, stableOk);
        checkOutput("b2b_99 bcd literal", 32'(bus.bcd_out), 32'h00099);
        sawDone = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) sawDone = 1'b1;
        end
        checkOutput("b2b no extra done", 32'(sawDone), 32'd0);

        $display("[TB] random conversions");
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 9) == 0) v = edgeVals[$urandom_range(0, 3)];
            else v = BIN_W'($urandom);
            s = 1'($urandom);
            applyStimulus($sformatf("rnd%0d", n), v, s, ((n % 4) == 0) ? 6 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
